// File: rtl/arm_enc_pkg.sv
// Shared types and field encodings for the ARMv4 data-processing instruction encoder.
package arm_enc_pkg;

  typedef enum logic [3:0] {
    OpAdd = 4'd0,
    OpSub = 4'd1,
    OpAnd = 4'd2,
    OpOrr = 4'd3,
    OpEor = 4'd4,
    OpMvn = 4'd5,
    OpLsl = 4'd7,
    OpLsr = 4'd8,
    OpAsr = 4'd9
  } op_e;

  localparam logic [3:0] CmdAdd = 4'b0100;
  localparam logic [3:0] CmdSub = 4'b0010;
  localparam logic [3:0] CmdAnd = 4'b0000;
  localparam logic [3:0] CmdOrr = 4'b1100;
  localparam logic [3:0] CmdEor = 4'b0001;
  localparam logic [3:0] CmdMvn = 4'b1111;
  // All shift ops are MOV with a shifted register operand.
  localparam logic [3:0] CmdMov = 4'b1101;

  localparam logic [1:0] ShLsl = 2'b00;
  localparam logic [1:0] ShLsr = 2'b01;
  localparam logic [1:0] ShAsr = 2'b10;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StDone,
    StErr
  } state_e;

endpackage

// File: rtl/dp_word_builder.sv
// Combinational field packer: operation request -> register-operand data-processing word.
module dp_word_builder
  import arm_enc_pkg::*;
(
  input  logic [3:0]  op_i,
  input  logic        s_i,
  input  logic [3:0]  cond_i,
  input  logic [3:0]  rd_i,
  input  logic [3:0]  rn_i,
  input  logic [3:0]  rm_i,
  input  logic [4:0]  shamt_i,
  output logic [31:0] word_o,
  output logic        illegal_o
);

  logic [3:0] cmd;
  logic [1:0] sh;
  logic       is_shift;
  logic       bad_op;
  logic [3:0] rn_eff;
  logic [4:0] shamt_eff;

  always_comb begin
    cmd      = CmdAnd;
    sh       = ShLsl;
    is_shift = 1'b0;
    bad_op   = 1'b0;
    unique case (op_i)
      OpAdd:   cmd = CmdAdd;
      OpSub:   cmd = CmdSub;
      OpAnd:   cmd = CmdAnd;
      OpOrr:   cmd = CmdOrr;
      OpEor:   cmd = CmdEor;
      OpMvn:   cmd = CmdMvn;
      OpLsl:   begin cmd = CmdMov; sh = ShLsl; is_shift = 1'b1; end
      OpLsr:   begin cmd = CmdMov; sh = ShLsr; is_shift = 1'b1; end
      OpAsr:   begin cmd = CmdMov; sh = ShAsr; is_shift = 1'b1; end
      default: bad_op = 1'b1;
    endcase
  end

  // MVN and MOV-shifts have no first operand; the decoder expects Rn = 0.
  assign rn_eff    = (is_shift || (op_i == OpMvn)) ? 4'd0 : rn_i;
  assign shamt_eff = is_shift ? shamt_i : 5'd0;
  assign illegal_o = bad_op || (is_shift && s_i);

  assign word_o = {cond_i, 2'b00, 1'b0, cmd, s_i, rn_eff, rd_i, shamt_eff, sh, 1'b0, rm_i};

endmodule

// File: rtl/dp_instr_encoder.sv
// Session FSM, one-word output register and address/count tracking for instruction loading.
module dp_instr_encoder
  import arm_enc_pkg::*;
#(
  parameter int unsigned MAX_WORDS = 64,
  parameter int unsigned CNT_W     = $clog2(MAX_WORDS + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [31:0]      base_addr,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [3:0]       req_op,
  input  logic             req_s,
  input  logic [3:0]       req_cond,
  input  logic [3:0]       req_rd,
  input  logic [3:0]       req_rn,
  input  logic [3:0]       req_rm,
  input  logic [4:0]       req_shamt,
  input  logic             req_last,
  output logic             mem_we,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  input  logic             mem_ready,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] word_count
);

  localparam logic [CNT_W:0] MaxCnt = (CNT_W + 1)'(MAX_WORDS);

  state_e           state_q, state_d;
  logic             mem_we_q, mem_we_d;
  logic [31:0]      mem_addr_q, mem_addr_d;
  logic [31:0]      mem_wdata_q, mem_wdata_d;
  logic             last_q, last_d;
  logic [CNT_W-1:0] word_count_q, word_count_d;

  logic [31:0]      enc_word;
  logic             enc_illegal;
  logic             write_hs;
  logic             accept;
  logic [CNT_W:0]   committed;
  logic             max_hit;

  dp_word_builder u_word_builder (
    .op_i      (req_op),
    .s_i       (req_s),
    .cond_i    (req_cond),
    .rd_i      (req_rd),
    .rn_i      (req_rn),
    .rm_i      (req_rm),
    .shamt_i   (req_shamt),
    .word_o    (enc_word),
    .illegal_o (enc_illegal)
  );

  assign write_hs  = mem_we_q && mem_ready;
  assign committed = {1'b0, word_count_q} + {{CNT_W{1'b0}}, mem_we_q};
  assign max_hit   = ({1'b0, word_count_q} + (CNT_W + 1)'(1)) == MaxCnt;

  // A queued last word closes the session; nothing more is taken behind it.
  assign req_ready = (state_q == StLoad) && (!mem_we_q || mem_ready) &&
                     !(mem_we_q && last_q) && (committed < MaxCnt);
  assign accept    = req_valid && req_ready;

  always_comb begin
    state_d      = state_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    last_d       = last_q;
    word_count_d = word_count_q;

    unique case (state_q)
      StIdle, StDone, StErr: begin
        if (start) begin
          state_d      = StLoad;
          mem_addr_d   = base_addr;
          word_count_d = '0;
          mem_we_d     = 1'b0;
          last_d       = 1'b0;
        end
      end
      StLoad: begin
        // mem_addr_q always names the slot of the held/next word, so it advances on handshakes.
        if (write_hs) begin
          mem_we_d     = 1'b0;
          mem_addr_d   = mem_addr_q + 32'd4;
          word_count_d = word_count_q + 1'b1;
          if (last_q || max_hit) begin
            state_d = StDone;
          end
        end
        if (accept) begin
          if (enc_illegal) begin
            // Accept implies the register is empty after this edge, so ERR sees it drained.
            state_d = StErr;
          end else begin
            mem_we_d    = 1'b1;
            mem_wdata_d = enc_word;
            last_d      = req_last;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      last_q       <= 1'b0;
      word_count_q <= '0;
    end else begin
      state_q      <= state_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      last_q       <= last_d;
      word_count_q <= word_count_d;
    end
  end

  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign word_count = word_count_q;
  assign busy       = (state_q == StLoad);
  assign done       = (state_q == StDone);
  assign err        = (state_q == StErr);

endmodule

// File: tb/tb_dp_instr_encoder.sv
// Scoreboard bench for dp_instr_encoder: directed cases plus randomized sessions with backpressure.
module tb_dp_instr_encoder;

  localparam int MaxWords = 4;
  localparam int CntW     = $clog2(MaxWords + 1);

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int          cyc;
    bit          chk_cyc;
  } exp_t;

  logic            clk = 1'b0;
  logic            reset;
  logic            start;
  logic [31:0]     base_addr;
  logic            req_valid;
  logic            req_ready;
  logic [3:0]      req_op;
  logic            req_s;
  logic [3:0]      req_cond;
  logic [3:0]      req_rd;
  logic [3:0]      req_rn;
  logic [3:0]      req_rm;
  logic [4:0]      req_shamt;
  logic            req_last;
  logic            mem_we;
  logic [31:0]     mem_addr;
  logic [31:0]     mem_wdata;
  logic            mem_ready = 1'b1;
  logic            busy;
  logic            done;
  logic            err;
  logic [CntW-1:0] word_count;

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  bit   bp_mode = 1'b0;
  bit   ready_hold = 1'b1;
  exp_t exp_q[$];

  // Session model: next expected address, legal words taken, end kind (0 open, 1 done, 2 err,
  // 3 aborted after a stimulus timeout).
  logic [31:0] m_addr;
  int          m_acc;
  int          m_end;

  int legal_ops[9] = '{0, 1, 2, 3, 4, 5, 7, 8, 9};

  dp_instr_encoder #(
    .MAX_WORDS (MaxWords)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .base_addr  (base_addr),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_s      (req_s),
    .req_cond   (req_cond),
    .req_rd     (req_rd),
    .req_rn     (req_rn),
    .req_rm     (req_rm),
    .req_shamt  (req_shamt),
    .req_last   (req_last),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_ready  (mem_ready),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .word_count (word_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin : ready_driver
    forever begin
      @(negedge clk);
      mem_ready = bp_mode ? ($urandom_range(0, 3) != 0) : ready_hold;
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // Reference encoding built from the field table: returns {illegal, word}.
  function automatic logic [32:0] ref_enc(input int op, input bit s, input logic [3:0] cond,
                                          input logic [3:0] rd, input logic [3:0] rn,
                                          input logic [3:0] rm, input logic [4:0] shamt);
    longint w;
    longint cmd;
    longint shc;
    longint rn_v;
    longint sa_v;
    bit     shift;
    bit     bad;
    cmd = 0; shc = 0; shift = 0; bad = 0;
    case (op)
      0: cmd = 4;
      1: cmd = 2;
      2: cmd = 0;
      3: cmd = 12;
      4: cmd = 1;
      5: cmd = 15;
      7, 8, 9: begin cmd = 13; shift = 1; shc = longint'(op - 7); end
      default: bad = 1;
    endcase
    if (shift && s) bad = 1;
    rn_v = (op == 5 || shift) ? 64'd0 : longint'(rn);
    sa_v = shift ? longint'(shamt) : 64'd0;
    w = (longint'(cond) << 28) + (cmd << 21) + (longint'(s) << 20) + (rn_v << 16) +
        (longint'(rd) << 12) + (sa_v << 7) + (shc << 5) + longint'(rm);
    return {bad, w[31:0]};
  endfunction

  task automatic start_session(input logic [31:0] base);
    @(negedge clk);
    start     = 1'b1;
    base_addr = base;
    @(posedge clk);
    #1 start = 1'b0;
    m_addr = base;
    m_acc  = 0;
    m_end  = 0;
    exp_q.delete();
  endtask

  task automatic send(input int op, input bit s, input logic [3:0] cond, input logic [3:0] rd,
                      input logic [3:0] rn, input logic [3:0] rm, input logic [4:0] shamt,
                      input bit last, input logic [31:0] lit, input bit chk_cyc);
    exp_t        e;
    logic [32:0] r;
    bit          got;
    int          acc_cyc;
    if (m_end != 0) return;
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = op[3:0];
    req_s     = s;
    req_cond  = cond;
    req_rd    = rd;
    req_rn    = rn;
    req_rm    = rm;
    req_shamt = shamt;
    req_last  = last;
    got       = 1'b0;
    acc_cyc   = 0;
    for (int w = 0; w < 50 && !got; w++) begin
      #1;
      if (req_ready) begin
        acc_cyc = cyc;
        @(posedge clk);
        got = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: req_ready stayed 0 for op %0d, required 1", op);
      req_valid = 1'b0;
      m_end = 3;
      return;
    end
    r = ref_enc(op, s, cond, rd, rn, rm, shamt);
    if (r[32]) begin
      m_end = 2;
    end else begin
      e.addr    = m_addr;
      e.data    = (lit != 32'd0) ? lit : r[31:0];
      e.cyc     = acc_cyc + 1;
      e.chk_cyc = chk_cyc;
      exp_q.push_back(e);
      m_addr = m_addr + 32'd4;
      m_acc++;
      if (last || m_acc == MaxWords) m_end = 1;
    end
  endtask

  task automatic finish_session();
    bit seen;
    @(negedge clk);
    req_valid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      #1;
      if (done || err) seen = 1'b1;
      else @(negedge clk);
    end
    if (m_end == 3) return;
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL session_end_timeout: done=%0b err=%0b, required one of them high", done, err);
      return;
    end
    chk("done", 32'(done), 32'(m_end == 1));
    chk("err", 32'(err), 32'(m_end == 2));
    chk("word_count_end", 32'(word_count), m_acc);
    chk("req_ready_end", 32'(req_ready), 32'd0);
    chk("sb_drained", exp_q.size(), 32'd0);
  endtask

  initial begin : monitor
    exp_t        e;
    bit          stall;
    logic [31:0] sa;
    logic [31:0] sd;
    stall = 1'b0;
    sa = '0;
    sd = '0;
    forever begin
      @(negedge clk);
      #2;
      if (!reset) begin
        stall = 1'b0;
        continue;
      end
      if (stall) begin
        chk("hold_we", 32'(mem_we), 32'd1);
        chk("hold_addr", mem_addr, sa);
        chk("hold_data", mem_wdata, sd);
      end
      stall = 1'b0;
      if (mem_we && mem_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, required no write",
                   mem_addr, mem_wdata);
        end else begin
          e = exp_q.pop_front();
          chk("wr_addr", mem_addr, e.addr);
          chk("wr_data", mem_wdata, e.data);
          if (e.chk_cyc) chk("wr_latency", cyc, e.cyc);
        end
      end else if (mem_we) begin
        stall = 1'b1;
        sa = mem_addr;
        sd = mem_wdata;
      end
    end
  end

  initial begin : stimulus
    int nreq;
    int op;
    int pick;
    bit s;
    bit last;

    reset = 1'b0; start = 1'b0; base_addr = '0; req_valid = 1'b0; req_op = '0; req_s = 1'b0;
    req_cond = '0; req_rd = '0; req_rn = '0; req_rm = '0; req_shamt = '0; req_last = 1'b0;
    m_addr = '0; m_acc = 0; m_end = 0;

    #1;
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_flags", {29'd0, busy, done, err}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_word_count", 32'(word_count), 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;

    // Back-to-back encodings with exact addresses, words and one-cycle latency.
    start_session(32'h100);
    @(negedge clk);
    #1;
    chk("start_busy", 32'(busy), 32'd1);
    chk("start_count", 32'(word_count), 32'd0);
    chk("start_addr", mem_addr, 32'h100);
    send(0, 0, 4'hE, 4'd1, 4'd2, 4'd3, 5'd0, 1'b0, 32'hE0821003, 1'b1);
    send(1, 1, 4'hE, 4'd4, 4'd5, 4'd6, 5'd0, 1'b0, 32'hE0554006, 1'b1);
    send(7, 0, 4'hE, 4'd0, 4'd9, 4'd1, 5'd4, 1'b0, 32'hE1A00201, 1'b1);
    send(5, 0, 4'hE, 4'd2, 4'd7, 4'd3, 5'd0, 1'b0, 32'hE1E02003, 1'b1);
    #2;
    chk("full_req_ready", 32'(req_ready), 32'd0);
    finish_session();

    // Backpressure: held word must not move and no second request slips in.
    start_session(32'h200);
    ready_hold = 1'b0;
    send(2, 0, 4'h0, 4'd7, 4'd8, 4'd9, 5'd3, 1'b0, 32'd0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      chk("bp_req_ready", 32'(req_ready), 32'd0);
      chk("bp_count", 32'(word_count), 32'd0);
    end
    @(posedge clk);
    ready_hold = 1'b1;
    send(3, 1, 4'h1, 4'd10, 4'd11, 4'd12, 5'd5, 1'b1, 32'd0, 1'b0);
    finish_session();

    // Illegal opcode and flag-setting shift both end in ERR with nothing written.
    start_session(32'h400);
    send(6, 0, 4'hE, 4'd1, 4'd1, 4'd1, 5'd0, 1'b0, 32'd0, 1'b0);
    finish_session();
    start_session(32'h500);
    send(8, 1, 4'hE, 4'd1, 4'd2, 4'd3, 5'd2, 1'b0, 32'd0, 1'b0);
    finish_session();
    start_session(32'h600);
    @(negedge clk);
    #1;
    chk("restart_busy", 32'(busy), 32'd1);
    chk("restart_err", 32'(err), 32'd0);
    chk("restart_count", 32'(word_count), 32'd0);
    chk("restart_addr", mem_addr, 32'h600);
    send(4, 1, 4'h3, 4'd5, 4'd6, 4'd7, 5'd0, 1'b1, 32'd0, 1'b0);
    finish_session();

    // Randomized sessions with random memory backpressure.
    bp_mode = 1'b1;
    for (int sidx = 0; sidx < 40; sidx++) begin
      start_session($urandom & 32'hFFFF_FFFC);
      nreq = int'($urandom_range(1, 6));
      for (int i = 0; i < nreq && m_end == 0; i++) begin
        if ($urandom_range(0, 3) == 0) begin
          @(negedge clk);
          req_valid = 1'b0;
        end
        pick = int'($urandom_range(0, 19));
        if (pick == 0) begin
          op = ($urandom_range(0, 1) == 0) ? 6 : int'($urandom_range(10, 15));
          s  = 1'($urandom_range(0, 1));
        end else if (pick == 1) begin
          op = int'($urandom_range(7, 9));
          s  = 1'b1;
        end else begin
          op = legal_ops[$urandom_range(0, 8)];
          s  = (op >= 7) ? 1'b0 : 1'($urandom_range(0, 1));
        end
        last = (i == nreq - 1) || ($urandom_range(0, 9) == 0);
        send(op, s, 4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), 5'($urandom),
             last, 32'd0, 1'b0);
      end
      finish_session();
    end
    bp_mode = 1'b0;

    // Reset while a write is stalled on the port.
    @(posedge clk);
    ready_hold = 1'b0;
    start_session(32'h700);
    send(0, 0, 4'hE, 4'd1, 4'd2, 4'd3, 5'd0, 1'b0, 32'd0, 1'b0);
    @(negedge clk);
    #1;
    chk("pre_reset_we", 32'(mem_we), 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("arst_mem_we", 32'(mem_we), 32'd0);
    chk("arst_mem_addr", mem_addr, 32'd0);
    chk("arst_mem_wdata", mem_wdata, 32'd0);
    chk("arst_count", 32'(word_count), 32'd0);
    chk("arst_flags", {28'd0, req_ready, busy, done, err}, 32'd0);
    exp_q.delete();
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    ready_hold = 1'b1;
    @(negedge clk);
    #1;
    chk("post_reset_idle", {28'd0, mem_we, busy, done, err}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dp_instr_encoder.md
# dp_instr_encoder

Sequential encoder that turns a stream of data-processing operation requests into 32-bit ARMv4 instruction words and writes them into instruction memory at consecutive word addresses. It is the inverse of the ALU decode path: it takes the ALUControl-style operation code plus flag-set request and produces the I/cmd/S/sh fields the decoder consumes. It sits between the test/program-loading logic and the instruction-memory write port. Only register-operand forms are emitted; these are the forms the ALU decoder resolves.

## Interface
- MAX_WORDS, 64, maximum words written per load session
- CNT_W, $clog2(MAX_WORDS+1), width of word_count
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  begin a load session at base_addr; honoured only in IDLE, DONE, ERR
- base_addr  in  32  byte address of first word, word-aligned
- req_valid  in  1  request valid
- req_ready  out  1  encoder can accept a request this cycle
- req_op  in  4  0 ADD, 1 SUB, 2 AND, 3 ORR, 4 EOR, 5 MVN, 7 LSL, 8 LSR, 9 ASR; others illegal
- req_s  in  1  set-flags bit
- req_cond  in  4  condition field
- req_rd, req_rn, req_rm  in  4 each  register numbers
- req_shamt  in  5  shift amount (shift ops only)
- req_last  in  1  final word of the session
- mem_we  out  1  write valid
- mem_addr  out  32  byte write address
- mem_wdata  out  32  encoded instruction
- mem_ready  in  1  memory accepts write when mem_we && mem_ready
- busy  out  1  state is LOAD
- done  out  1  state is DONE
- err  out  1  state is ERR
- word_count  out  CNT_W  words written this session

## Operation
- Word layout: [31:28] cond, [27:26] 00, [25] I=0, [24:21] cmd, [20] S, [19:16] Rn, [15:12] Rd, [11:7] shamt, [6:5] sh, [4] 0, [3:0] Rm.
- cmd: ADD 0100, SUB 0010, AND 0000, ORR 1100, EOR 0001, MVN 1111, shifts 1101. sh: LSL 00, LSR 01, ASR 10; 00 for non-shift ops.
- shamt forced 0 for non-shift ops. Rn forced 0 for MVN and shifts.
- Illegal: op code outside the list; shift op with req_s=1.
- States: IDLE, LOAD, DONE, ERR.
  - IDLE→LOAD on start: addr←base_addr, word_count←0.
  - LOAD: accept requests.
    - Illegal request: consumed, not written, →ERR once the output register has drained.
    - Write handshake with req_last, or word_count reaching MAX_WORDS: →DONE.
  - DONE/ERR→LOAD on start; re-initialises addr and count.
- Output register holds one word. req_ready = busy && (!mem_we || mem_ready) && word_count + pending < MAX_WORDS.
- Each write handshake: mem_addr += 4, word_count += 1.

## Timing
- Reset: state IDLE; mem_we, req_ready, busy, done, err = 0; mem_addr, mem_wdata, word_count = 0.
- Latency: request accepted at edge N → mem_we=1 with word from cycle N+1.
- mem_we, mem_addr and mem_wdata are held stable while mem_ready=0.
- Throughput is one word per cycle when mem_ready stays high.
- Accept and write in the same cycle: the output register reloads; no bubble.
- start while in LOAD: ignored.
- Reset mid-session: immediate return to IDLE; a write pending on the port is dropped.
- MAX_WORDS reached: req_ready is 0 from the cycle the last slot is committed.

## Structure
- Package arm_enc_pkg holds:
  - op enum with the codes above
  - cmd and sh constants
  - state enum
- Sub-module dp_word_builder: combinational fields → {word, illegal}.
- Top module holds the FSM, output register, address and counter.

## Test plan
- ADD: start, base 0x100; op 0, s 0, cond E, rd 1, rn 2, rm 3 → mem_addr 0x100, mem_wdata 0xE0821003 one cycle after accept.
- SUBS: op 1, s 1, rd 4, rn 5, rm 6 → 0xE0554006. LSL: op 7, rd 0, rm 1, shamt 4 → 0xE1A00201. MVN: op 5, rd 2, rm 3 → 0xE1E02003. Issue back-to-back → addresses 0x100, 0x104, 0x108, 0x10C.
- Backpressure: mem_ready held low 3 cycles → word and address stable, req_ready 0, no request lost; word_count increments once.
- Illegal: op 6 → no write, err=1 after drain. Shift with s=1 → same result. Then start → LOAD with word_count 0.
- Full: MAX_WORDS=4, no req_last → done after 4th write; req_ready 0 thereafter.
- Mid-stream reset with mem_we=1 → all outputs 0 asynchronously; state IDLE after release.
